// File: rtl/ram_port_sequencer.sv
`timescale 1ns/1ps
// ram_port_sequencer: burst initiator for the dual-port state/coefficient RAM.
// Write bursts drain the wr stream onto port 1 (bidirectional data bus),
// read bursts fetch through port 2 into a one-entry output register.
// Optional feature macro: MEMSEQ_FILL_EN adds cmd_fill (zero-fill write bursts).
module ram_port_sequencer #(
  parameter int ADDRESS_SIZE = 4,
  parameter int WORD_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS_SIZE-1:0] cmd_addr,
  input  logic [ADDRESS_SIZE-1:0] cmd_len,
`ifdef MEMSEQ_FILL_EN
  input  logic                    cmd_fill,
`endif
  input  logic                    wr_valid,
  input  logic [WORD_SIZE-1:0]    wr_data,
  output logic                    wr_ready,
  output logic                    rd_valid,
  output logic [WORD_SIZE-1:0]    rd_data,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr1,
  inout  wire  [WORD_SIZE-1:0]    mem_data1,
  output logic [ADDRESS_SIZE-1:0] mem_addr2,
  input  logic [WORD_SIZE-1:0]    mem_data2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [ADDRESS_SIZE-1:0] rem_q, rem_d;     // words left after the current one
  logic                    more_q, more_d;   // read: words still to fetch
  logic                    rd_valid_q, rd_valid_d;
  logic [WORD_SIZE-1:0]    rd_data_q, rd_data_d;
  logic                    done_q, done_d;
  logic                    fill_q;
  logic                    wr_hs, cap;
  logic [WORD_SIZE-1:0]    wdata;

`ifdef MEMSEQ_FILL_EN
  logic fill_d;
`else
  assign fill_q = 1'b0;
`endif

  // A write word commits on every WRITE cycle with data offered (or always when filling)
  assign wr_hs = (state_q == S_WRITE) && (fill_q || wr_valid);
  // Output register can take a new word when empty or being drained this cycle
  assign cap   = (state_q == S_READ) && more_q && (!rd_valid_q || rd_ready);

  // Next-state logic for burst control and the read output register
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    more_d     = more_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
`ifdef MEMSEQ_FILL_EN
    fill_d     = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          more_d  = 1'b1;
          state_d = cmd_write ? S_WRITE : S_READ;
`ifdef MEMSEQ_FILL_EN
          fill_d  = cmd_write & cmd_fill;
`endif
        end
      end
      S_WRITE: begin
        if (wr_hs) begin
          addr_d = addr_q + 1'b1;
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      S_READ: begin
        if (cap) begin
          rd_data_d  = mem_data2;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          if (rem_q == '0) more_d = 1'b0;
          else             rem_d  = rem_q - 1'b1;
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
        end
        // Burst ends once the last fetched word has been handed over
        if (rd_valid_q && rd_ready && !more_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any burst in flight without a done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      more_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
`ifdef MEMSEQ_FILL_EN
      fill_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      more_q     <= more_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
`ifdef MEMSEQ_FILL_EN
      fill_q     <= fill_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wr_ready  = (state_q == S_WRITE) && !fill_q;
  assign mem_we    = wr_hs;
  assign mem_addr1 = (state_q == S_WRITE) ? addr_q : '0;
  assign mem_addr2 = (state_q == S_READ)  ? addr_q : '0;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wdata     = fill_q ? '0 : wr_data;
  // Port 1 bus released whenever no write is happening so the RAM may drive it
  assign mem_data1 = mem_we ? wdata : 'z;

endmodule
